// File: rtl/fetch_align_ctrl.sv
// fetch_align_ctrl: single-outstanding word fetch feeding a 3-halfword align queue.
// Optional feature macro C_EXT_EN enables 16-bit compressed instructions.
module fetch_align_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_is_c_o,
  input  logic        inst_ready_i,
  output logic        misalign_exc_o
);
  typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALT} state_t;

  state_t           state, state_nx;
  logic [2:0][15:0] q, q_nx;
  logic [1:0]       count, cnt_nx;
  logic [31:0]      pc_q, fa;
  logic             skip, halt_pend, halt_nx, exc_q;
  logic             head_c, redir_bad, req_raw, valid_raw, deliver, push, grant;

`ifdef C_EXT_EN
  assign head_c    = (q[0][1:0] != 2'b11);
  assign redir_bad = 1'b0;
`else
  assign head_c    = 1'b0;
  assign redir_bad = redirect_pc_i[1];
`endif

  assign req_raw   = (state == RUN) && (count <= 2'd1) && !redirect_i;
  assign valid_raw = !redirect_i && (state != HALT) &&
                     ((count >= 2'd2) || ((count != 2'd0) && head_c));
  assign grant     = req_raw && imem_gnt_i;
  assign deliver   = valid_raw && inst_ready_i;
  assign push      = (state == WAIT) && imem_rvalid_i && !redirect_i;

  assign imem_req_o     = !reset && req_raw;
  assign imem_addr_o    = reset ? 32'h0 : fa;
  assign inst_valid_o   = !reset && valid_raw;
  assign inst_o         = reset ? 32'h0 : (head_c ? {16'h0, q[0]} : {q[1], q[0]});
  assign inst_pc_o      = reset ? 32'h0 : pc_q;
  assign inst_is_c_o    = !reset && head_c;
  assign misalign_exc_o = !reset && exc_q;

  // Pop first, then append the response halves behind whatever remains.
  always_comb begin
    q_nx   = q;
    cnt_nx = count;
    if (deliver) begin
      if (head_c) begin
        q_nx[0] = q[1];
        q_nx[1] = q[2];
        cnt_nx  = count - 2'd1;
      end else begin
        q_nx[0] = q[2];
        cnt_nx  = count - 2'd2;
      end
    end
    if (push) begin
      if (skip) begin
        case (cnt_nx)
          2'd0:    q_nx[0] = imem_rdata_i[31:16];
          2'd1:    q_nx[1] = imem_rdata_i[31:16];
          default: q_nx[2] = imem_rdata_i[31:16];
        endcase
        cnt_nx = cnt_nx + 2'd1;
      end else begin
        if (cnt_nx == 2'd0) begin
          q_nx[0] = imem_rdata_i[15:0];
          q_nx[1] = imem_rdata_i[31:16];
        end else begin
          q_nx[1] = imem_rdata_i[15:0];
          q_nx[2] = imem_rdata_i[31:16];
        end
        cnt_nx = cnt_nx + 2'd2;
      end
    end
  end

  always_comb begin
    state_nx = state;
    halt_nx  = halt_pend;
    case (state)
      RUN:     if (grant) state_nx = WAIT;
      WAIT:    if (imem_rvalid_i) state_nx = RUN;
      DRAIN:   if (imem_rvalid_i) state_nx = halt_pend ? HALT : RUN;
      default: state_nx = HALT;
    endcase
    if (redirect_i) begin
      halt_nx = redir_bad;
      // A response arriving this very cycle is the outstanding one; nothing left to drain.
      if ((state == WAIT || state == DRAIN) && !imem_rvalid_i) state_nx = DRAIN;
      else state_nx = redir_bad ? HALT : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      q         <= '0;
      count     <= 2'd0;
      pc_q      <= RESET_PC & ~32'h1;
      fa        <= RESET_PC & ~32'h3;
      skip      <= RESET_PC[1];
      halt_pend <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      halt_pend <= halt_nx;
      exc_q     <= redirect_i && redir_bad;
      if (redirect_i) begin
        count <= 2'd0;
        pc_q  <= redirect_pc_i & ~32'h1;
        fa    <= redirect_pc_i & ~32'h3;
        skip  <= redirect_pc_i[1];
      end else begin
        q     <= q_nx;
        count <= cnt_nx;
        if (deliver) pc_q <= pc_q + (head_c ? 32'd2 : 32'd4);
        if (grant) fa <= fa + 32'd4;
        if (push && skip) skip <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_align_ctrl.sv
// tb_fetch_align_ctrl: random fetch/redirect/stall stimulus; a halfword-stream model
// fills a scoreboard that an independent monitor checks at every decode handshake.
`timescale 1ns/1ps
module tb_fetch_align_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o, inst_pc_o;
  logic        inst_is_c_o, misalign_exc_o;
  logic        inst_ready_i = 1'b0;

  int checks = 0, errors = 0, nhs = 0;
  bit hold_ready = 0;
  int pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_align_ctrl #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_is_c_o(inst_is_c_o), .inst_ready_i(inst_ready_i), .misalign_exc_o(misalign_exc_o)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory image, filled lazily with random words; shared by responder and model.
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction
  function automatic logic [15:0] half_at(input logic [31:0] pc);
    logic [31:0] w;
    w = word_at({pc[31:2], 2'b00});
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: the instruction stream is a walk over halfwords starting at the PC.
  typedef struct packed { logic [31:0] inst; logic [31:0] pc; logic is_c; } exp_t;
  exp_t exp_q[$];
  logic [31:0] m_pc;
  bit m_halt;

  function automatic void refill();
    logic [15:0] lo, hi;
    logic is_c;
    exp_t e;
    while (!m_halt && exp_q.size() < 8) begin
      lo = half_at(m_pc);
`ifdef C_EXT_EN
      is_c = (lo[1:0] != 2'b11);
`else
      is_c = 1'b0;
`endif
      if (is_c) begin
        e = '{inst: {16'h0, lo}, pc: m_pc, is_c: 1'b1};
        m_pc = m_pc + 32'd2;
      end else begin
        hi = half_at(m_pc + 32'd2);
        e = '{inst: {hi, lo}, pc: m_pc, is_c: 1'b0};
        m_pc = m_pc + 32'd4;
      end
      exp_q.push_back(e);
    end
  endfunction

  function automatic void restart(input logic [31:0] tgt);
    exp_q.delete();
    m_pc = tgt & ~32'h1;
`ifdef C_EXT_EN
    m_halt = 1'b0;
`else
    m_halt = tgt[1];
`endif
    refill();
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0:       t = 32'h100;
      1:       t = 32'h102;
      2:       t = 32'h200;
      3:       t = 32'hFFFF_FFF8;
      default: t = $urandom_range(0, 32'hFFF);
    endcase
`ifndef C_EXT_EN
    t[1] = 1'b0;
`endif
    return t;
  endfunction

  // One cycle of stimulus plus the memory responder; inputs change on negedge.
  task automatic step(input bit redir, input logic [31:0] tgt);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word_at(pend_addr);
      end
    end
    imem_gnt_i    = ($urandom_range(0, 3) != 0);
    inst_ready_i  = !hold_ready && ($urandom_range(0, 3) != 0);
    redirect_i    = redir;
    redirect_pc_i = tgt;
    if (redir) restart(tgt);
    refill();
    #1;
    if (imem_req_o && imem_gnt_i) begin
      chk("one_outstanding", {pend_cnt != 0, imem_addr_o[1:0]}, 3'b000);
      pend_addr = imem_addr_o;
      pend_cnt  = $urandom_range(1, 3);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold-stability and exceptions.
  initial begin
    exp_t e;
    bit held, prev_bad, exc_exp;
    logic [64:0] saved;
    held = 0; prev_bad = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) continue;
      if (redirect_i) chk("redirect_blocks", {imem_req_o, inst_valid_o}, 2'b00);
`ifdef C_EXT_EN
      exc_exp = 1'b0;
`else
      exc_exp = prev_bad;
`endif
      chk("misalign_exc", misalign_exc_o, exc_exp);
      prev_bad = redirect_i && redirect_pc_i[1];
      if (inst_valid_o) begin
        if (held) chk("hold_stable", {inst_o, inst_pc_o, inst_is_c_o}, saved);
        if (inst_ready_i) begin
          held = 0;
          if (exp_q.size() == 0) chk("unexpected_inst", inst_pc_o, 32'hxxxx_xxxx);
          else begin
            e = exp_q.pop_front();
            chk("inst_pc", {inst_o, inst_pc_o}, {e.inst, e.pc});
            chk("inst_is_c", inst_is_c_o, e.is_c);
            nhs++;
          end
        end else begin
          held  = 1;
          saved = {inst_o, inst_pc_o, inst_is_c_o};
        end
      end else held = 0;
    end
  end

  initial begin
    bit r;
    logic [31:0] t;
    mem[32'h000] = 32'h00A0_0093;
    mem[32'h100] = 32'h4501_4505;
    mem[32'h200] = 32'h0093_4505;
    mem[32'h204] = 32'h1234_00A0;
    restart(32'h0);
    repeat (3) begin
      @(negedge clk);
      #1 chk("reset_outputs", {imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
                               inst_is_c_o, misalign_exc_o}, '0);
    end
    reset = 1'b0;
    step(0, 32'h0);
    chk("first_req", {imem_req_o, imem_addr_o}, {1'b1, 32'h0});

    for (int i = 0; i < 3000; i++) begin
      hold_ready = ((i % 250) >= 200);
      r = !hold_ready && ($urandom_range(0, 29) == 0);
      t = pick_target();
      step(r, t);
      if ((i % 250) >= 245) chk("stall_full", {imem_req_o, inst_valid_o}, 2'b01);
      if (i == 1500) begin
        hold_ready = 0;
        step(1, 32'h202);
`ifndef C_EXT_EN
        repeat (12) begin
          step(0, 32'h0);
          chk("halted", {imem_req_o, inst_valid_o}, 2'b00);
        end
        step(1, 32'h300);
        for (int k = 0; k < 30 && !imem_req_o; k++) step(0, 32'h0);
        chk("resume_addr", {imem_req_o, imem_addr_o}, {1'b1, 32'h300});
`endif
      end
    end
    hold_ready = 0;
    repeat (20) step(0, 32'h0);
    chk("progress", nhs > 200, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_align_ctrl.md
# fetch_align_ctrl

Instruction-fetch controller between the word-aligned instruction memory port and the decode stage. Issues one-outstanding 32-bit fetch requests and keeps a 3-entry halfword queue. Assembles 16-bit compressed and possibly halfword-misaligned 32-bit instructions into one instruction per handshake. Redirects from branch/jump resolution flush the queue and discard in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, PC of first instruction after reset (bit 0 ignored)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- redirect_i  in  1  taken branch/jump; flush and refetch
- redirect_pc_i  in  32  redirect target (bit 0 ignored)
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  word address, bits[1:0] always 0
- imem_gnt_i  in  1  request accepted when imem_req_o & imem_gnt_i
- imem_rvalid_i  in  1  response valid, ≥1 cycle after grant
- imem_rdata_i  in  32  response word, little-endian halves
- inst_valid_o  out  1  instruction available to decode
- inst_o  out  32  instruction; compressed in [15:0], [31:16]=0
- inst_pc_o  out  32  PC of inst_o
- inst_is_c_o  out  1  inst_o is 16-bit
- inst_ready_i  in  1  decode accepts when inst_valid_o & inst_ready_i
- misalign_exc_o  out  1  redirect to halfword target without C extension (1-cycle pulse)

## Operation
- State: fsm {RUN, WAIT, DRAIN, HALT}, queue q[0..2] of 16 bits, count 0..3, pc_q (next PC to deliver), fa (next fetch word address), skip flag.
- Reset: fsm=RUN, count=0, pc_q=RESET_PC&~1, fa=RESET_PC&~3, skip=RESET_PC[1]. While reset is high, all outputs are 0.
- RUN: imem_req_o=1 when count≤1 and !redirect_i. imem_addr_o=fa. On grant: fa+=4, go WAIT. imem_req_o stays asserted until grant; it drops only on redirect.
- WAIT: imem_req_o=0. On imem_rvalid_i, push halves and go RUN.
  - skip=1: push rdata[31:16] only, then clear skip.
  - skip=0: push rdata[15:0], then rdata[31:16].
- Head q[0] is compressed iff q[0][1:0]!=2'b11.
- inst_valid_o=1 when !redirect_i and either (count≥1 and head compressed) or count≥2.
  - Compressed: inst_o={16'b0,q[0]}.
  - 32-bit: inst_o={q[1],q[0]}.
- On handshake: pop 1 (compressed) or 2 halves; pc_q+=2 or 4. Pop and push in the same cycle are allowed; pop applies first and push appends after remaining entries. Count never exceeds 3.
- Redirect (priority over everything, any state except reset): count=0, pc_q=target&~1, fa=target&~3, skip=target[1].
  - From WAIT without same-cycle rvalid: go DRAIN.
  - From WAIT with same-cycle rvalid: response discarded, go RUN.
  - From DRAIN: stay DRAIN.
  - Otherwise: go RUN.
- DRAIN: imem_req_o=0. The next imem_rvalid_i is discarded, then go RUN.
- Wrap-around: pc_q and fa wrap modulo 2^32.

## Timing
- Single outstanding request. With a 1-cycle memory, max throughput is one word per 2 cycles.
- First request is asserted the cycle after reset deasserts.
- Fetch-to-issue latency: response in cycle N, inst_valid_o in N+1 (registered queue).
- Redirect in cycle N: inst_valid_o=0 and imem_req_o=0 in N. New request in N+1 from RUN, or in the cycle after the stale response from DRAIN.
- inst_o, inst_pc_o and inst_is_c_o are stable while inst_valid_o=1 and inst_ready_i=0.
- inst_valid_o and imem_req_o depend combinationally on redirect_i. All other outputs are registered-state decodes.

## Configuration
- C_EXT_EN defined: behaviour as above. misalign_exc_o is tied 0. HALT is unreachable.
- C_EXT_EN undefined:
  - Every instruction is treated as 32-bit: inst_is_c_o=0, and 2 halves are required per instruction.
  - A redirect with target[1]=1 pulses misalign_exc_o for one cycle, flushes, and goes to HALT (or to DRAIN first if a response is outstanding, then HALT).
  - HALT: no requests, inst_valid_o=0. Exit only on a redirect to a word-aligned target.

## Test plan
- Reset with RESET_PC=0. Memory returns 0x00A0_0093 at addr 0 after 1 cycle -> one 32-bit instruction, inst_pc_o=0, inst_is_c_o=0; next request to 0x4.
- Word 0x4501_4505 at 0 -> two compressed instructions: 0x4505 at PC 0, then 0x4501 at PC 2, both with inst_is_c_o=1.
- Misaligned straddle: word0=0x0093_4505, word1=0xXXXX_00A0 -> 0x4505 at PC 0, then 0x00A0_0093 at PC 2.
- Redirect to 0x102 while WAIT -> stale response dropped (DRAIN). Request addr 0x100; only the upper half of the response is used; first inst_pc_o=0x102.
- Hold inst_ready_i=0 for 5 cycles with count=3 -> imem_req_o stays 0 and outputs stay stable. Redirect and handshake in the same cycle -> no pop, inst_valid_o=0.
- C_EXT_EN undefined, redirect to 0x202 -> misalign_exc_o=1 for one cycle and no further requests. Then redirect to 0x300 -> fetch resumes at 0x300.
